if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC and drives the instruction SRAM.
- Produces the IF→ID bus and a stable instruction word for decode. The word holds across IF/ID stalls, so decode no longer latches SRAM data itself.
- Keeps any branch/jump redirect from decode that arrives while the PC is stalled and applies it on the first unstalled cycle.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- STALL_W, 6, width of the pipeline stall vector (`StallBus).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  STALL_W  pipeline stall vector; bit0 = PC stall, bit1 = IF/ID stall; 1 = Stop
- br_bus  in  33  {br_e, br_addr[31:0]} from decode
- if_to_id_bus  out  33  {ce, pc[31:0]}
- id_inst  out  32  instruction word presented to decode
- inst_sram_en  out  1  SRAM enable
- inst_sram_wen  out  4  always 4'b0000
- inst_sram_addr  out  32  fetch address
- inst_sram_wdata  out  32  always 32'b0
- inst_sram_rdata  in  32  SRAM read data, valid the cycle after the address
- if_adel  out  1  fetch address misaligned (pc[1:0] != 0), qualified by ce
- fetch_cnt  out  32  count of instructions accepted by decode

Behaviour:
- Reset (clk edge with rst=1):
  - state=S_IDLE; pc_reg=RESET_PC-4; ce=0.
  - br_pend=0; br_pend_addr=0.
  - hold_valid=0; hold_inst=0; fetch_cnt=0.
  - All outputs are 0 except the constant wen/wdata.
  - A reset asserted mid-stall or mid-hold discards the pending branch and the held instruction.
- FSM:
  - S_IDLE → S_RUN on the first cycle after reset deasserts. In that cycle pc_reg loads RESET_PC and ce becomes 1.
  - S_RUN → S_HOLD when stall[1]=1 and ce=1 at a clock edge.
  - S_HOLD → S_RUN at the first edge where stall[1]=0.
- Next-PC priority:
  1. Live br_e=1.
  2. br_pend=1 (use br_pend_addr).
  3. pc_reg+4.
- PC update:
  - pc_reg updates only when stall[0]=0. While stall[0]=1, pc_reg and ce hold.
  - br_e=1 while stall[0]=1 sets br_pend=1 and br_pend_addr=br_addr. A later br_e during the same stall overwrites it.
  - br_pend clears on the edge where pc_reg consumes it (stall[0]=0).
- SRAM interface:
  - inst_sram_en = ce after the next-PC update (combinational from the registered next fetch state). During S_IDLE it is 1 only on the cycle that launches RESET_PC.
  - inst_sram_addr = next-PC value while stall[0]=0; pc_reg while stalled, i.e. re-issue the same address.
  - Data for the address launched at edge N is valid after edge N+1.
- IF→ID register:
  - stall[1]=1 and stall[2]=0: bubble (33'b0).
  - stall[1]=0: load {ce, pc_reg}.
  - Otherwise hold.
- Instruction hold:
  - On entry to S_HOLD, hold_inst ← inst_sram_rdata and hold_valid ← 1. No further capture while in S_HOLD.
  - id_inst = hold_valid ? hold_inst : inst_sram_rdata.
  - hold_valid clears on the S_HOLD→S_RUN edge; id_inst then returns to the SRAM path.
- if_adel = ce & (pc[1:0] != 2'b00) on the IF→ID bus. Fetch still proceeds; squashing is handled downstream.
- fetch_cnt:
  - Increments by 1 on each edge where stall[1]=0 and the ce loaded into IF→ID is 1.
  - Wraps 32'hFFFF_FFFF→0. Unaffected by stall[0] alone.
- Simultaneous events:
  - br_e with stall[0]=0 takes effect immediately and also clears any br_pend.
  - stall[1] rising in the same cycle as a branch: the redirect is still applied (or pended) independently of the hold capture.

Test Plan:
- Reset release with no stalls → sram_addr sequence 0xBFC0_0000, 0xBFC0_0004, 0xBFC0_0008; if_to_id pc lags one cycle; ce=1 from the first fetch; fetch_cnt=3 after 3 accepts.
- br_bus={1, 0xBFC0_0100} with pc=0xBFC0_0008 → next sram_addr=0xBFC0_0100, then 0xBFC0_0104.
- stall[0]=1 for 3 cycles with br_e pulsed once (addr 0xBFC0_0200) in cycle 1 → PC frozen; after release the next fetch is 0xBFC0_0200; br_pend=0 afterwards.
- stall[1]=1 for 4 cycles while SRAM returns 0x2401_0005 then garbage → id_inst stays 0x2401_0005 throughout; fetch_cnt unchanged; after release id_inst follows SRAM.
- stall[1]=1, stall[2]=0 → if_to_id_bus=0 next cycle (bubble); pc_reg held.
- Branch to 0xBFC0_0102 → if_adel=1 with that pc on the bus; rst mid-hold → hold_valid=0, pc_reg=RESET_PC-4, fetch_cnt=0.

Source files
------------

// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
//
// Instruction-SRAM port bundle between the fetch stage and instruction memory.
//
// Signals:
//   inst_sram_en     fetch side -> memory   read enable for this cycle
//   inst_sram_wen    fetch side -> memory   byte write enables (fetch never writes)
//   inst_sram_addr   fetch side -> memory   byte address being launched
//   inst_sram_wdata  fetch side -> memory   write data (unused by fetch)
//   inst_sram_rdata  memory -> fetch side   read data, one cycle after the address
//
// Modports:
//   master  used by the fetch stage
//   slave   used by the memory model / SRAM wrapper
// ---------------------------------------------------------------------------
interface if_fetch_if;

   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   modport master (
      output inst_sram_en,
      output inst_sram_wen,
      output inst_sram_addr,
      output inst_sram_wdata,
      input  inst_sram_rdata
   );

   modport slave (
      input  inst_sram_en,
      input  inst_sram_wen,
      input  inst_sram_addr,
      input  inst_sram_wdata,
      output inst_sram_rdata
   );

endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC,
// launches fetch addresses into the instruction SRAM, and hands decode the
// IF->ID bus together with a stable instruction word. While the IF/ID
// register is stalled the instruction returned by the SRAM is captured once
// and replayed, so decode never has to latch SRAM data itself. A redirect
// arriving from decode while the PC is frozen is remembered and applied on
// the first cycle the PC is allowed to move again.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   STALL_W    width of the pipeline stall vector
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   stall          stall vector; bit0 freezes the PC, bit1 freezes IF/ID,
//                  bit2 freezes ID/EX (used to choose bubble vs hold)
//   br_bus         {br_e, br_addr[31:0]} redirect request from decode
//   sram           instruction SRAM port (master side)
//   if_to_id_bus   {ce, pc[31:0]} registered IF->ID bus
//   id_inst        instruction word presented to decode
//   if_adel        misaligned fetch address on the IF->ID bus (ce qualified)
//   fetch_cnt      number of instructions accepted by decode (wraps)
// ---------------------------------------------------------------------------
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [32:0]        br_bus,
   if_fetch_if.master         sram,
   output logic [32:0]        if_to_id_bus,
   output logic [31:0]        id_inst,
   output logic               if_adel,
   output logic [31:0]        fetch_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] pc_reg;
   logic        ce;

   logic        br_pend;
   logic [31:0] br_pend_addr;

   logic        hold_valid;
   logic [31:0] hold_inst;

   logic [32:0] if_id_reg;

   logic        br_e;
   logic [31:0] br_addr;
   logic        pc_stall;
   logic        ifid_stall;
   logic        idex_stall;
   logic [31:0] pc_seq;
   logic [31:0] next_pc;

   logic        hold_capture;
   logic        hold_release;

   // Stall bits beyond ID/EX belong to later stages and do not affect fetch.
   logic        unused_stall_hi;

   assign br_e       = br_bus[32];
   assign br_addr    = br_bus[31:0];
   assign pc_stall   = stall[0];
   assign ifid_stall = stall[1];
   assign idex_stall = stall[2];

   assign unused_stall_hi = ^stall[STALL_W-1:3];

   // -------------------------------------------------------------------------
   // Next fetch address. A live redirect always wins; otherwise a redirect
   // that was remembered during a PC stall; otherwise fall through to the
   // sequential address. Reset parks pc_reg at RESET_PC-4 so the sequential
   // path naturally produces RESET_PC for the very first fetch.
   // -------------------------------------------------------------------------
   always_comb begin
      pc_seq  = pc_reg + 32'd4;
      next_pc = pc_seq;
      if (br_e) begin
         next_pc = br_addr;
      end else if (br_pend) begin
         next_pc = br_pend_addr;
      end
   end

   // -------------------------------------------------------------------------
   // FSM state register.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next-state logic. IDLE lasts exactly one cycle after reset so the
   // reset vector gets launched; RUN and HOLD track whether decode is
   // currently refusing the instruction on the IF->ID bus.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            state_next = S_RUN;
         end
         S_RUN: begin
            if (ifid_stall && ce) begin
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!ifid_stall) begin
               state_next = S_RUN;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM output logic. The capture strobe fires only on the RUN->HOLD edge so
   // the word sampled is the one belonging to the instruction decode is
   // stalled on; later SRAM data during the stall is ignored.
   // -------------------------------------------------------------------------
   always_comb begin
      hold_capture = 1'b0;
      hold_release = 1'b0;
      case (state)
         S_RUN: begin
            hold_capture = ifid_stall && ce;
         end
         S_HOLD: begin
            hold_release = !ifid_stall;
         end
         default: begin
            hold_capture = 1'b0;
            hold_release = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // PC register and fetch-valid flag. Both freeze while the PC is stalled;
   // ce becomes 1 on the first real PC update and stays there until reset.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg <= RESET_PC - 32'd4;
         ce     <= 1'b0;
      end else if (!pc_stall) begin
         pc_reg <= next_pc;
         ce     <= 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Pending redirect. A branch seen while the PC is frozen would otherwise be
   // lost because decode only drives br_e for one cycle. The most recent one
   // wins. Any unstalled edge either consumes the pending address or has
   // been overridden by a live branch, so the flag clears either way.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         br_pend      <= 1'b0;
         br_pend_addr <= 32'b0;
      end else if (pc_stall) begin
         if (br_e) begin
            br_pend      <= 1'b1;
            br_pend_addr <= br_addr;
         end
      end else begin
         br_pend <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Instruction hold buffer. The SRAM only guarantees data for one cycle
   // after the address, so while decode is stalled we keep our own copy.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_inst  <= 32'b0;
      end else if (hold_capture) begin
         hold_valid <= 1'b1;
         hold_inst  <= sram.inst_sram_rdata;
      end else if (hold_release) begin
         hold_valid <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // IF->ID pipeline register. When IF/ID stalls but ID/EX keeps moving,
   // decode's current instruction advances, so we must feed it a bubble
   // instead of duplicating the instruction. If both stall, simply hold.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_reg <= 33'b0;
      end else if (ifid_stall && !idex_stall) begin
         if_id_reg <= 33'b0;
      end else if (!ifid_stall) begin
         if_id_reg <= {ce, pc_reg};
      end
   end

   // -------------------------------------------------------------------------
   // Accepted-instruction counter. An instruction counts when a valid fetch
   // is transferred into IF/ID; a PC-only stall does not block the transfer.
   // The counter wraps naturally on overflow.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= 32'b0;
      end else if (!ifid_stall && ce) begin
         fetch_cnt <= fetch_cnt + 32'd1;
      end
   end

   // -------------------------------------------------------------------------
   // SRAM drive. While the PC is stalled the current pc_reg is re-issued so
   // the read data stays aligned with the instruction waiting in IF. The
   // enable reflects the fetch-valid flag after this cycle's update, which
   // is always 1 once the PC moves. Everything is forced quiet during reset.
   // -------------------------------------------------------------------------
   always_comb begin
      sram.inst_sram_wen   = 4'b0000;
      sram.inst_sram_wdata = 32'b0;
      sram.inst_sram_en    = 1'b0;
      sram.inst_sram_addr  = 32'b0;
      if (!rst) begin
         if (pc_stall) begin
            sram.inst_sram_en   = ce;
            sram.inst_sram_addr = pc_reg;
         end else begin
            sram.inst_sram_en   = 1'b1;
            sram.inst_sram_addr = next_pc;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Decode-facing outputs. The held word takes precedence over the live SRAM
   // data; the address-error flag only matters for a valid fetch and does not
   // stop the fetch itself, squashing happens further down the pipe.
   // -------------------------------------------------------------------------
   always_comb begin
      id_inst = 32'b0;
      if (!rst) begin
         id_inst = hold_valid ? hold_inst : sram.inst_sram_rdata;
      end
   end

   assign if_to_id_bus = if_id_reg;
   assign if_adel      = if_id_reg[32] & (if_id_reg[1:0] != 2'b00);

endmodule
